// File: rtl/if_stage_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM encoding,
// the bubble instruction and the PC increment.
package if_stage_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_stage_unit_ifid_reg.sv
// IF/ID pipeline register: load captures a fetched instruction, bubble
// replaces it with NOP/valid=0 while keeping the last pc/pc4, otherwise holds.
module if_stage_unit_ifid_reg #(
    parameter int                 ADDR_W  = 32,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [ADDR_W-1:0]  pc4_in,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid
);

    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0]  pc_d, pc_q, pc4_d, pc4_q;
    logic               valid_d, valid_q;

    // Next-state selection: load beats bubble, bubble beats hold.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end else if (bubble) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_q <= NOP;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign ifid_instr = instr_q;
    assign ifid_pc    = pc_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;

endmodule

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC register, fetch FSM driving the instruction
// memory handshake, and the IF/ID pipeline register.
module if_stage_unit
    import if_stage_unit_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = INSTR_W'(NOP_INSTR)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               PC_LE,
    input  logic               IFID_LE,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q, addr_d, addr_q, pc_inc_s;
    logic              req_d, req_q;
    logic              redirect_s, ifid_load_s, ifid_bubble_s;

    assign pc_inc_s   = pc_q + INC;
    assign redirect_s = branch_taken && PC_LE;

    // Fetch FSM next state, PC selection and IF/ID control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        ifid_load_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (redirect_s) begin
                    pc_d          = branch_target;
                    ifid_bubble_s = 1'b1;
                    if (imem_ready) begin
                        state_d = FETCH;
                        addr_d  = branch_target;
                    end else begin
                        // Outstanding request must keep its address until it completes.
                        state_d = DROP;
                        addr_d  = pc_q;
                    end
                end else begin
                    if (PC_LE && imem_ready) begin
                        pc_d = pc_inc_s;
                    end else begin
                        pc_d = pc_q;
                    end
                    addr_d        = pc_d;
                    ifid_load_s   = IFID_LE && imem_ready;
                    ifid_bubble_s = IFID_LE && !imem_ready;
                end
            end
            DROP: begin
                ifid_bubble_s = redirect_s || IFID_LE;
                if (redirect_s) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ready && !redirect_s) begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end else begin
                    state_d = DROP;
                    addr_d  = addr_q;
                end
            end
            default: begin
                state_d = BOOT;
                addr_d  = pc_q;
            end
        endcase
        req_d = (state_d != BOOT);
    end

    // State, PC and registered memory-request outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    if_stage_unit_ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .NOP     (NOP)
    ) u_ifid_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (ifid_load_s),
        .bubble     (ifid_bubble_s),
        .instr_in   (imem_data),
        .pc_in      (pc_q),
        .pc4_in     (pc_inc_s),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

endmodule
